// File: rtl/mux_scan_seq.sv
// mux_scan_seq: control and capture stage around a 16:1 bit multiplexer.
// On an accepted start it walks `sel` through the enabled channels in
// ascending order. It holds each channel for SETTLE extra cycles, then samples
// `mux_out` into the matching bit of `word`. When the last enabled channel has
// been sampled, it presents the finished word with a one-cycle `valid` pulse.
//
// Optional feature: define MUX_SCAN_PARITY_EN to add the registered `parity`
// output, which is the XOR of the captured word.

module mux_scan_seq #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mask,
    input  logic        mux_out,
    output logic [3:0]  sel,
    output logic        ready,
    output logic [15:0] word,
`ifdef MUX_SCAN_PARITY_EN
    output logic        parity,
`endif
    output logic        valid
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

    state_t      state;
    state_t      state_next;
    logic [3:0]  sel_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [15:0] scan_mask;
    logic [15:0] scan_mask_next;
    logic [15:0] word_next;
    logic [15:0] above;
`ifdef MUX_SCAN_PARITY_EN
    logic        parity_next;
`endif

    // Index of the lowest set bit; only called with a non-zero argument.
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = 4'(i);
            end
        end
    endfunction

    // State, select, settle counter, latched mask and capture word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 4'd0;
            cnt       <= 4'd0;
            scan_mask <= 16'd0;
            word      <= 16'd0;
`ifdef MUX_SCAN_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            cnt       <= cnt_next;
            scan_mask <= scan_mask_next;
            word      <= word_next;
`ifdef MUX_SCAN_PARITY_EN
            parity    <= parity_next;
`endif
        end
    end

    // Next-state logic: start acceptance, per-channel settle countdown, sampling and skipping of disabled channels.
    always_comb begin
        state_next     = state;
        sel_next       = sel;
        cnt_next       = cnt;
        scan_mask_next = scan_mask;
        word_next      = word;
`ifdef MUX_SCAN_PARITY_EN
        parity_next    = parity;
`endif
        // Channels strictly above the one currently selected that are still enabled.
        above          = scan_mask & (16'hFFFF << ({1'b0, sel} + 5'd1));

        case (state)
            IDLE: begin
                sel_next = 4'd0;
                if (start) begin
                    scan_mask_next = mask;
                    word_next      = 16'd0;
`ifdef MUX_SCAN_PARITY_EN
                    parity_next    = 1'b0;
`endif
                    if (mask == 16'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SCAN;
                        sel_next   = lowest_set(mask);
                        cnt_next   = SETTLE_LOAD;
                    end
                end
            end

            SCAN: begin
                if (cnt == 4'd0) begin
                    word_next[sel] = mux_out;
                    if (above == 16'd0) begin
                        state_next  = DONE;
                        sel_next    = 4'd0;
`ifdef MUX_SCAN_PARITY_EN
                        parity_next = ^word_next;
`endif
                    end else begin
                        sel_next = lowest_set(above);
                        cnt_next = SETTLE_LOAD;
                    end
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end

            DONE: begin
                state_next = IDLE;
                sel_next   = 4'd0;
            end

            default: begin
                state_next = IDLE;
                sel_next   = 4'd0;
            end
        endcase
    end

    // Handshake outputs decode straight from the registered state.
    assign ready = (state == IDLE);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_mux_scan_seq.sv
// Testbench for mux_scan_seq. Three instances run with SETTLE = 1, 0 and 15.
// Each instance's mux is modelled as mux_out = pattern[sel]. Expected words
// go into a scoreboard queue when a scan starts. Each entry is popped and
// compared when `valid` appears.

module tb_mux_scan_seq;

    typedef struct {
        logic [15:0] w;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start   [3];
    logic [15:0] mask    [3];
    logic [15:0] pattern [3];
    logic        mux_out [3];
    logic [3:0]  sel     [3];
    logic        ready   [3];
    logic [15:0] word    [3];
    logic        valid   [3];
`ifdef MUX_SCAN_PARITY_EN
    logic        parity  [3];
`endif

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    assign mux_out[0] = pattern[0][sel[0]];
    assign mux_out[1] = pattern[1][sel[1]];
    assign mux_out[2] = pattern[2][sel[2]];

    mux_scan_seq #(.SETTLE(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start[0]), .mask(mask[0]), .mux_out(mux_out[0]),
        .sel(sel[0]), .ready(ready[0]), .word(word[0]),
`ifdef MUX_SCAN_PARITY_EN
        .parity(parity[0]),
`endif
        .valid(valid[0])
    );

    mux_scan_seq #(.SETTLE(0)) dut_s0 (
        .clk(clk), .rst(rst), .start(start[1]), .mask(mask[1]), .mux_out(mux_out[1]),
        .sel(sel[1]), .ready(ready[1]), .word(word[1]),
`ifdef MUX_SCAN_PARITY_EN
        .parity(parity[1]),
`endif
        .valid(valid[1])
    );

    mux_scan_seq #(.SETTLE(15)) dut_s15 (
        .clk(clk), .rst(rst), .start(start[2]), .mask(mask[2]), .mux_out(mux_out[2]),
        .sel(sel[2]), .ready(ready[2]), .word(word[2]),
`ifdef MUX_SCAN_PARITY_EN
        .parity(parity[2]),
`endif
        .valid(valid[2])
    );

    function automatic int settle_of(input int u);
        case (u)
            0:       return 1;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    // Start one scan on unit u and follow it cycle by cycle until ready returns.
    // This is entered and left on a falling edge. With busy set, start is raised
    // again (with a zero mask) through SCAN and DONE.
    task automatic run_scan(input int u, input logic [15:0] m, input logic [15:0] pat,
                            input string name, input bit busy);
        int          s;
        int          n;
        int          vc;
        int          chan[16];
        logic [3:0]  exp_sel;
        exp_t        e;
        exp_t        got;
        s = settle_of(u);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                chan[n] = i;
                n++;
            end
        end
        vc    = n * (s + 1) + 1;
        e.w   = m & pat;
        e.cyc = vc;
        exp_q.push_back(e);

        mask[u]    = m;
        pattern[u] = pat;
        start[u]   = 1'b1;
        for (int c = 1; c <= vc + 1; c++) begin
            @(negedge clk);
            if (c == 1) start[u] = 1'b0;
            exp_sel = (n > 0 && c < vc) ? 4'(chan[(c - 1) / (s + 1)]) : 4'd0;
            tests_run++;
            if (sel[u] !== exp_sel) begin
                tests_failed++;
                $display("[TB] FAIL %s sel cycle %0d: got %0d expected %0d", name, c, sel[u], exp_sel);
            end
            tests_run++;
            if (ready[u] !== (c > vc)) begin
                tests_failed++;
                $display("[TB] FAIL %s ready cycle %0d: got %b expected %b", name, c, ready[u], (c > vc));
            end
            if (valid[u] === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s unexpected valid cycle %0d: got 1 expected 0", name, c);
                end else begin
                    got = exp_q.pop_front();
                    tests_run++;
                    if (c != got.cyc) begin
                        tests_failed++;
                        $display("[TB] FAIL %s valid cycle: got %0d expected %0d", name, c, got.cyc);
                    end
                    if (word[u] !== got.w) begin
                        tests_failed++;
                        $display("[TB] FAIL %s word: got %h expected %h", name, word[u], got.w);
                    end
`ifdef MUX_SCAN_PARITY_EN
                    tests_run++;
                    if (parity[u] !== ^got.w) begin
                        tests_failed++;
                        $display("[TB] FAIL %s parity: got %b expected %b", name, parity[u], ^got.w);
                    end
`endif
                end
            end
            if (c == vc + 1) begin
                tests_run++;
                if (word[u] !== e.w) begin
                    tests_failed++;
                    $display("[TB] FAIL %s word hold: got %h expected %h", name, word[u], e.w);
                end
            end
            if (busy && c == 5) begin
                start[u] = 1'b1;
                mask[u]  = 16'h0000;
            end
            if (busy && c == vc) start[u] = 1'b0;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s missing valid: got none expected cycle %0d", name, vc);
        end
        exp_q.delete();

        if (busy) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                tests_run++;
                if (valid[u] !== 1'b0 || ready[u] !== 1'b1 || word[u] !== e.w) begin
                    tests_failed++;
                    $display("[TB] FAIL %s after busy: got valid=%b ready=%b word=%h expected valid=0 ready=1 word=%h",
                             name, valid[u], ready[u], word[u], e.w);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            start[u]   = 1'b0;
            mask[u]    = 16'h0000;
            pattern[u] = 16'h0000;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            tests_run++;
            if (sel[u] !== 4'd0 || word[u] !== 16'd0 || valid[u] !== 1'b0 || ready[u] !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset unit %0d: got sel=%0d word=%h valid=%b ready=%b expected 0/0000/0/1",
                         u, sel[u], word[u], valid[u], ready[u]);
            end
`ifdef MUX_SCAN_PARITY_EN
            tests_run++;
            if (parity[u] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset parity unit %0d: got %b expected 0", u, parity[u]);
            end
`endif
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_scan();
        run_scan(0, 16'hFFFF, 16'hA5C3, "full_scan", 1'b0);
    endtask

    task automatic test_sparse_mask();
        run_scan(1, 16'h8001, 16'hFFFF, "sparse_mask", 1'b0);
    endtask

    task automatic test_empty_mask();
        run_scan(1, 16'h0000, 16'hFFFF, "empty_mask", 1'b0);
    endtask

    task automatic test_start_busy();
        run_scan(0, 16'hFFFF, 16'h3C5A, "start_busy", 1'b1);
    endtask

    task automatic test_back_to_back();
        run_scan(1, 16'h0006, 16'h0004, "b2b_first", 1'b0);
        run_scan(1, 16'h00F0, 16'h0050, "b2b_second", 1'b0);
        run_scan(1, 16'h1234, 16'hFFFF, "b2b_third", 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        mask[0]    = 16'hFFFF;
        pattern[0] = 16'hA5C3;
        start[0]   = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if (sel[0] !== 4'd4 || word[0] !== 16'h0003) begin
            tests_failed++;
            $display("[TB] FAIL mid_scan before reset: got sel=%0d word=%h expected sel=4 word=0003", sel[0], word[0]);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (sel[0] !== 4'd0 || word[0] !== 16'd0 || ready[0] !== 1'b1 || valid[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_scan reset: got sel=%0d word=%h ready=%b valid=%b expected 0/0000/1/0",
                     sel[0], word[0], ready[0], valid[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (valid[0] !== 1'b0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL mid_scan aborted valid: got %b expected 0", valid[0]);
            end
        end
        run_scan(0, 16'hFFFF, 16'hA5C3, "after_reset", 1'b0);
    endtask

    task automatic test_settle_max();
        run_scan(2, 16'h0003, 16'h0002, "settle_max", 1'b0);
    endtask

    // Runs every scenario in sequence, then prints the summary.
    initial begin
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_empty_mask();
        test_start_busy();
        test_back_to_back();
        test_reset_mid_scan();
        test_settle_max();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
